// File: rtl/rr_arbiter_hold_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The arbiter takes the slave side; the requester side drives go and observes the grant.
interface rr_arbiter_hold_if #(
   parameter int N = 4
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  go;
   logic [N-1:0]  get;
   logic [IW-1:0] get_idx;
   logic          get_vld;

   modport master (output go, input get, input get_idx, input get_vld);
   modport slave  (input go, output get, output get_idx, output get_vld);
endinterface

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with burst ownership capped at MAX_HOLD cycles.
// Grant, grant index and valid are all registered; the search is combinational on go.
module rr_arbiter_hold #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4
) (
   input logic               clk,
   input logic               rst,
   rr_arbiter_hold_if.slave  bus
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] CAP = CW'(MAX_HOLD);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [CW-1:0] hold_cnt, hold_nxt;
   logic [N-1:0]  get_r, get_nxt;
   logic [IW-1:0] idx_r, idx_nxt;
   logic          vld_r, vld_nxt;
   logic          found;
   logic [IW-1:0] win;
   logic          keep;

   // Scanning from ptr+1 with ptr itself last serves idle arbitration,
   // handover and forced rotation alike, since ptr always names the last owner.
   always_comb begin
      int t;
      t     = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N; k++) begin
         t = int'(ptr) + 1 + k;
         if (t >= N) t = t - N;
         if (!found && bus.go[IW'(t)]) begin
            found = 1'b1;
            win   = IW'(t);
         end
      end
   end

   assign keep = (state == GRANT) && bus.go[ptr] && (hold_cnt < CAP);

   // Owner keeps the grant below the cap; otherwise the scan result wins,
   // and with no requests at all we fall back to idle leaving ptr untouched.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      get_nxt   = '0;
      idx_nxt   = '0;
      vld_nxt   = 1'b0;
      if (keep) begin
         hold_nxt     = hold_cnt + CW'(1);
         get_nxt[ptr] = 1'b1;
         idx_nxt      = ptr;
         vld_nxt      = 1'b1;
      end else if (found) begin
         state_nxt    = GRANT;
         ptr_nxt      = win;
         hold_nxt     = CW'(1);
         get_nxt[win] = 1'b1;
         idx_nxt      = win;
         vld_nxt      = 1'b1;
      end else begin
         state_nxt = IDLE;
         hold_nxt  = '0;
      end
   end

   // Reset parks ptr on N-1 so the very first search starts at requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= IW'(N - 1);
         hold_cnt <= '0;
         get_r    <= '0;
         idx_r    <= '0;
         vld_r    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         get_r    <= get_nxt;
         idx_r    <= idx_nxt;
         vld_r    <= vld_nxt;
      end
   end

   assign bus.get     = get_r;
   assign bus.get_idx = idx_r;
   assign bus.get_vld = vld_r;
endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold: one instance with MAX_HOLD=4 and one with
// MAX_HOLD=1, sharing clock and reset, each checked against hand-derived grants.
module tb_rr_arbiter_hold;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rr_arbiter_hold_if #(.N(4)) bus4 ();
   rr_arbiter_hold_if #(.N(4)) bus1 ();

   rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   rr_arbiter_hold #(.N(4), .MAX_HOLD(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge, so outputs are sampled away from it.
   task automatic applyStimulus(input logic [3:0] g4, input logic [3:0] g1);
      bus4.go = g4;
      bus1.go = g1;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag,
                              input logic [3:0] obsGet, input logic [1:0] obsIdx, input logic obsVld,
                              input logic [3:0] expGet, input logic [1:0] expIdx, input logic expVld,
                              input bit chkIdx);
      checks++;
      assert (obsGet === expGet) else begin
         errors++;
         $error("[TB] FAIL %s get observed %b expected %b", tag, obsGet, expGet);
      end
      checks++;
      assert (obsVld === expVld) else begin
         errors++;
         $error("[TB] FAIL %s get_vld observed %b expected %b", tag, obsVld, expVld);
      end
      if (chkIdx) begin
         checks++;
         assert (obsIdx === expIdx) else begin
            errors++;
            $error("[TB] FAIL %s get_idx observed %0d expected %0d", tag, obsIdx, expIdx);
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      logic [3:0] eg;
      logic [1:0] ei;

      rst     = 1'b1;
      bus4.go = 4'b0000;
      bus1.go = 4'b0000;
      #12;
      checkOutput("in_reset", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0000, 2'd0, 1'b0, 1'b1);
      rst = 1'b0;

      // Idle after reset: nothing requested, nothing granted.
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0000, 4'b0000);
         checkOutput("idle", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0000, 2'd0, 1'b0, 1'b1);
      end

      // All requesting: each owner holds for 4 cycles, then rotation, wrapping back to 0.
      for (int c = 0; c < 17; c++) begin
         applyStimulus(4'b1111, 4'b0000);
         eg = 4'b0001 << ((c / 4) % 4);
         ei = 2'((c / 4) % 4);
         checkOutput("all_req", bus4.get, bus4.get_idx, bus4.get_vld, eg, ei, 1'b1, 1'b1);
      end

      applyStimulus(4'b0000, 4'b0000);
      checkOutput("drop_to_idle", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Lone requester is re-granted across the cap with no bubble.
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b0001, 4'b0000);
         checkOutput("lone_req", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0001, 2'd0, 1'b1, 1'b1);
      end

      applyStimulus(4'b0101, 4'b0000);
      checkOutput("no_preempt", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0001, 2'd0, 1'b1, 1'b1);
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("handover", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0100, 2'd2, 1'b1, 1'b1);

      // Owner 2 drops: scan 3,0,1 picks requester 1.
      applyStimulus(4'b0010, 4'b0000);
      checkOutput("grant_1", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0010, 2'd1, 1'b1, 1'b1);

      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst", bus4.get, bus4.get_idx, bus4.get_vld, 4'b0000, 2'd0, 1'b0, 1'b1);
      rst = 1'b0;
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("after_rst", bus4.get, bus4.get_idx, bus4.get_vld, 4'b1000, 2'd3, 1'b1, 1'b1);

      // MAX_HOLD=1: requesters 0 and 2 alternate every cycle.
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b0000, 4'b0101);
         eg = (c % 2 == 0) ? 4'b0001 : 4'b0100;
         ei = (c % 2 == 0) ? 2'd0 : 2'd2;
         checkOutput("hold1_alt", bus1.get, bus1.get_idx, bus1.get_vld, eg, ei, 1'b1, 1'b1);
         checks++;
         assert ($onehot(bus1.get)) else begin
            errors++;
            $error("[TB] FAIL hold1_onehot get observed %b expected one-hot", bus1.get);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
